// File: rtl/home_sequencer.sv
// home_sequencer: command-level sequencer for the G28 homing engine.
// Homes Z first, waits a settle gap, then homes X/Y together. Debounces the
// raw endstops for the engine and reports done / error / homed status.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for a command, cmd_ready high
// S_Z_HOME  | engine driving Z toward its endstop
// S_SETTLE  | gap between Z and XY phases, engine stopped
// S_XY_HOME | engine driving the requested X/Y axes
// S_DONE    | one-cycle completion pulse
// S_ERROR   | timeout or abort, held until the next accepted command
module home_sequencer #(
   parameter int unsigned DEBOUNCE = 16,
   parameter int unsigned SETTLE   = 1000
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        cmd_valid_i,
   input  logic [2:0]  cmd_axes_i,
   output logic        cmd_ready_o,
   input  logic        abort_i,
   input  logic [31:0] timeout_cycles_i,
   input  logic        xmin_raw_i,
   input  logic        ymin_raw_i,
   input  logic        zmin_raw_i,
   output logic        xmin_o,
   output logic        ymin_o,
   output logic        zmin_o,
   output logic        homex_o,
   output logic        homey_o,
   output logic        homez_o,
   output logic        start_driving_o,
   output logic        busy_o,
   output logic        done_o,
   output logic        error_o,
   output logic [2:0]  err_axes_o,
   output logic [2:0]  homed_o
);

   localparam int unsigned DBW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
   localparam int unsigned SW  = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [DBW-1:0] DB_LAST     = DBW'(DEBOUNCE - 1);
   localparam logic [SW-1:0]  SETTLE_LOAD = SW'(SETTLE - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_Z_HOME,
      S_SETTLE,
      S_XY_HOME,
      S_DONE,
      S_ERROR
   } state_t;

   logic [2:0]     raw;
   logic [2:0]     sync1_q, sync2_q, filt_q;
   logic [DBW-1:0] db_cnt_q [3];

   state_t         state_q, state_d;
   logic [2:0]     req_q, req_d;
   logic [2:0]     homed_q, homed_d;
   logic [2:0]     err_axes_q, err_axes_d;
   logic [31:0]    timer_q, timer_d;
   logic [SW-1:0]  settle_q, settle_d;

   logic           cmd_ready_q, busy_q, done_q, error_q;
   logic           homex_q, homey_q, homez_q, start_q;

   logic           accept;
   logic           tmo_hit;
   logic [31:0]    timer_inc;
   logic [1:0]     xy_open;

   assign raw = {zmin_raw_i, ymin_raw_i, xmin_raw_i};

   // Synchronize each raw endstop, then only follow it after DEBOUNCE stable cycles.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sync1_q <= '0;
         sync2_q <= '0;
         filt_q  <= '0;
         for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
         for (int i = 0; i < 3; i++) begin
            if (sync2_q[i] != filt_q[i]) begin
               if (db_cnt_q[i] == DB_LAST) begin
                  filt_q[i]   <= sync2_q[i];
                  db_cnt_q[i] <= '0;
               end else begin
                  db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
               end
            end else begin
               db_cnt_q[i] <= '0;
            end
         end
      end
   end

   assign accept    = cmd_valid_i & cmd_ready_q;
   // The timer saturates so a disabled timeout can never wrap into a false hit.
   assign timer_inc = (&timer_q) ? timer_q : timer_q + 32'd1;
   assign tmo_hit   = (timeout_cycles_i != 32'd0) && (timer_q == timeout_cycles_i - 32'd1);
   assign xy_open   = req_q[1:0] & ~filt_q[1:0];

   // Next-state logic: abort beats completion, completion beats timeout.
   always_comb begin
      state_d    = state_q;
      req_d      = req_q;
      homed_d    = homed_q;
      err_axes_d = err_axes_q;
      timer_d    = timer_q;
      settle_d   = settle_q;
      case (state_q)
         S_IDLE, S_ERROR: begin
            if (accept) begin
               req_d      = cmd_axes_i;
               homed_d    = homed_q & ~cmd_axes_i;
               err_axes_d = 3'b000;
               timer_d    = 32'd0;
               if (cmd_axes_i[2])            state_d = S_Z_HOME;
               else if (|cmd_axes_i[1:0])    state_d = S_XY_HOME;
               else                          state_d = S_DONE;
            end
         end
         S_Z_HOME: begin
            timer_d = timer_inc;
            if (abort_i) begin
               state_d    = S_ERROR;
               err_axes_d = 3'b000;
            end else if (filt_q[2]) begin
               homed_d[2] = 1'b1;
               settle_d   = SETTLE_LOAD;
               state_d    = S_SETTLE;
            end else if (tmo_hit) begin
               err_axes_d = 3'b100 & ~{filt_q[2], 2'b00};
               state_d    = S_ERROR;
            end
         end
         S_SETTLE: begin
            if (abort_i) begin
               state_d    = S_ERROR;
               err_axes_d = 3'b000;
            end else if (settle_q == '0) begin
               timer_d = 32'd0;
               state_d = (|req_q[1:0]) ? S_XY_HOME : S_DONE;
            end else begin
               settle_d = settle_q - 1'b1;
            end
         end
         S_XY_HOME: begin
            timer_d = timer_inc;
            if (abort_i) begin
               state_d    = S_ERROR;
               err_axes_d = 3'b000;
            end else begin
               homed_d[1:0] = homed_q[1:0] | (req_q[1:0] & filt_q[1:0]);
               if (xy_open == 2'b00) begin
                  state_d = S_DONE;
               end else if (tmo_hit) begin
                  err_axes_d = {1'b0, xy_open};
                  state_d    = S_ERROR;
               end
            end
         end
         S_DONE: begin
            if (abort_i) begin
               state_d    = S_ERROR;
               err_axes_d = 3'b000;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State registers, with every output decoded from the next state so it lands on the same edge.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= S_IDLE;
         req_q       <= '0;
         homed_q     <= '0;
         err_axes_q  <= '0;
         timer_q     <= '0;
         settle_q    <= '0;
         cmd_ready_q <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         homex_q     <= 1'b0;
         homey_q     <= 1'b0;
         homez_q     <= 1'b0;
         start_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         req_q       <= req_d;
         homed_q     <= homed_d;
         err_axes_q  <= err_axes_d;
         timer_q     <= timer_d;
         settle_q    <= settle_d;
         cmd_ready_q <= (state_d == S_IDLE) || (state_d == S_ERROR);
         busy_q      <= (state_d == S_Z_HOME) || (state_d == S_SETTLE) ||
                        (state_d == S_XY_HOME) || (state_d == S_DONE);
         done_q      <= (state_d == S_DONE);
         error_q     <= (state_d == S_ERROR);
         homex_q     <= (state_d == S_XY_HOME) && req_d[0];
         homey_q     <= (state_d == S_XY_HOME) && req_d[1];
         homez_q     <= (state_d == S_Z_HOME);
         start_q     <= (state_d == S_Z_HOME) || (state_d == S_XY_HOME);
      end
   end

   assign cmd_ready_o     = cmd_ready_q;
   assign busy_o          = busy_q;
   assign done_o          = done_q;
   assign error_o         = error_q;
   assign err_axes_o      = err_axes_q;
   assign homed_o         = homed_q;
   assign homex_o         = homex_q;
   assign homey_o         = homey_q;
   assign homez_o         = homez_q;
   assign start_driving_o = start_q;
   assign xmin_o          = filt_q[0];
   assign ymin_o          = filt_q[1];
   assign zmin_o          = filt_q[2];

endmodule
